// File: rtl/big_core_cr_arb.sv
// Two-requester (core LSU / fabric) arbiter in front of the big_core CR memory port.
// Optional macro CR_ARB_FABRIC_WR_EN forwards fabric writes; without it they are dropped.
module big_core_cr_arb #(
    parameter int unsigned MAX_CORE_STREAK = 4,
    parameter int unsigned CR_ADDR_W       = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 core_req_valid,
    input  logic                 core_req_wren,
    input  logic [CR_ADDR_W-1:0] core_req_addr,
    input  logic [31:0]          core_req_data,
    output logic                 core_req_ready,
    output logic                 core_rsp_valid,
    output logic [31:0]          core_rsp_data,
    input  logic                 fab_req_valid,
    input  logic                 fab_req_wren,
    input  logic [CR_ADDR_W-1:0] fab_req_addr,
    input  logic [31:0]          fab_req_data,
    output logic                 fab_req_ready,
    output logic                 fab_rsp_valid,
    output logic [31:0]          fab_rsp_data,
    output logic [31:0]          cr_address,
    output logic [31:0]          cr_data,
    output logic                 cr_wren,
    output logic                 cr_rden,
    input  logic [31:0]          cr_q,
    output logic                 fab_wr_drop
);

    localparam logic [0:0] StCorePri = 1'b0;
    localparam logic [0:0] StFabPri  = 1'b1;
    localparam logic [3:0] MaxStreak = 4'(MAX_CORE_STREAK);

    logic [0:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        grant_core, grant_fab, fab_fwd, drop_set;

    logic        s1_wr_q, s1_wr_d, s1_rd_q, s1_rd_d, s1_owner_q, s1_owner_d;
    logic [31:0] s1_addr_q, s1_addr_d, s1_data_q, s1_data_d;
    logic        s2_valid_q, s2_owner_q;
    logic        drop_q;

    always_comb begin
        grant_core = 1'b0;
        grant_fab  = 1'b0;
        if (!Rst) begin
            if (core_req_valid && fab_req_valid) begin
                if (state_q == StFabPri) grant_fab = 1'b1;
                else                     grant_core = 1'b1;
            end else begin
                grant_core = core_req_valid;
                grant_fab  = fab_req_valid;
            end
        end
    end

    assign core_req_ready = grant_core;
    assign fab_req_ready  = grant_fab;

`ifdef CR_ARB_FABRIC_WR_EN
    assign fab_fwd  = grant_fab;
    assign drop_set = 1'b0;
`else
    assign fab_fwd  = grant_fab && !fab_req_wren;
    assign drop_set = grant_fab && fab_req_wren;
`endif

    always_comb begin
        streak_d = streak_q;
        if (!fab_req_valid || grant_fab) begin
            streak_d = 4'd0;
        end else if (grant_core && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
        end

        state_d = state_q;
        if (state_q == StCorePri && streak_d >= MaxStreak) begin
            state_d = StFabPri;
        end else if (state_q == StFabPri && grant_fab) begin
            state_d = StCorePri;
        end
    end

    // Strobe stage loads zeros when idle so the CR port rests at 0.
    always_comb begin
        s1_wr_d    = 1'b0;
        s1_rd_d    = 1'b0;
        s1_owner_d = 1'b0;
        s1_addr_d  = '0;
        s1_data_d  = '0;
        if (grant_core) begin
            s1_wr_d   = core_req_wren;
            s1_rd_d   = !core_req_wren;
            s1_addr_d = 32'(core_req_addr);
            s1_data_d = core_req_data;
        end else if (fab_fwd) begin
            s1_wr_d    = fab_req_wren;
            s1_rd_d    = !fab_req_wren;
            s1_owner_d = 1'b1;
            s1_addr_d  = 32'(fab_req_addr);
            s1_data_d  = fab_req_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StCorePri;
            streak_q   <= 4'd0;
            s1_wr_q    <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_owner_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_owner_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            s1_wr_q    <= s1_wr_d;
            s1_rd_q    <= s1_rd_d;
            s1_owner_q <= s1_owner_d;
            s1_addr_q  <= s1_addr_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s1_rd_q;
            s2_owner_q <= s1_owner_q;
            drop_q     <= drop_q | drop_set;
        end
    end

    // Outputs are masked by Rst so in-flight stages die in the reset cycle itself.
    assign cr_wren    = s1_wr_q && !Rst;
    assign cr_rden    = s1_rd_q && !Rst;
    assign cr_address = Rst ? 32'd0 : s1_addr_q;
    assign cr_data    = Rst ? 32'd0 : s1_data_q;

    assign core_rsp_valid = s2_valid_q && !s2_owner_q && !Rst;
    assign fab_rsp_valid  = s2_valid_q && s2_owner_q && !Rst;
    assign core_rsp_data  = core_rsp_valid ? cr_q : 32'd0;
    assign fab_rsp_data   = fab_rsp_valid ? cr_q : 32'd0;

    assign fab_wr_drop = drop_q && !Rst;

endmodule
